// File: rtl/i2s_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_sequencer_if
// Stereo sample handshake between the voice mixer (master) and the I2S
// transmit sequencer (slave).
//   s_valid  master->slave  sample pair valid
//   s_ready  slave->master  sequencer can take a pair this cycle
//   s_left   master->slave  left sample, two's complement
//   s_right  master->slave  right sample, two's complement
// ---------------------------------------------------------------------------
interface i2s_tx_sequencer_if #(
  parameter int SAMPLE_W = 24
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_tx_sequencer
// Generates the I2S bit clock and word select from clk, buffers one stereo
// pair, and shifts out one frame per pair: MSB first, one-bit I2S delay,
// zero-padded slots. A frame boundary with nothing buffered sends a silent
// frame and sets a sticky underflow flag.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   enable         run request, looked at in IDLE and at frame boundaries
//   s_if           sample handshake (slave side)
//   underflow_clr  clears the underflow flag
//   i2s_sclk       bit clock (period 2*CLK_DIV clk)
//   i2s_lrclk      word select, 0 = left slot, 1 = right slot
//   i2s_data       serial data, updated on sclk falling edges only
//   frame_start    one-cycle pulse whenever a frame (or silent frame) loads
//   underflow      sticky underflow flag
//   busy           sequencer not idle
// ---------------------------------------------------------------------------
module i2s_tx_sequencer #(
  parameter int CLK_DIV  = 2,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  i2s_tx_sequencer_if.slave     s_if,
  input  logic                  underflow_clr,
  output logic                  i2s_sclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_data,
  output logic                  frame_start,
  output logic                  underflow,
  output logic                  busy
);

  localparam int BW = $clog2(2 * SLOT_W);  // frame bit index width
  localparam int PW = $clog2(SLOT_W);      // bit-within-slot width
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [BW-1:0]       b_q, b_d;
  logic                sclk_q, sclk_d;
  logic                lrclk_q, lrclk_d;
  logic                data_q, data_d;
  logic                fs_q, fs_d;
  logic                uf_q, uf_d;
  logic                pend_vld_q, pend_vld_d;
  logic [SAMPLE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [SAMPLE_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [SAMPLE_W-1:0] prev_r_q, prev_r_d;
  logic                accept;
  logic                shift_out;
  logic                uf_set;

  // Serial bit for frame position b. Because of the one-bit delay, b
  // carries the bit of position b-1; b = 0 therefore carries the last slot
  // bit of the previous frame's right channel. Shifting the sample left by
  // the slot position drops padding positions off the top, so they read 0.
  function automatic logic slot_bit(input logic [BW-1:0]       b,
                                    input logic [SAMPLE_W-1:0] l,
                                    input logic [SAMPLE_W-1:0] r,
                                    input logic [SAMPLE_W-1:0] prev);
    logic [BW-1:0]       d;
    logic [SAMPLE_W-1:0] ch;
    logic [SAMPLE_W-1:0] sh;
    d = b - BW'(1);
    if (b == '0)      ch = prev;
    else if (d[BW-1]) ch = r;
    else              ch = l;
    sh = ch << d[PW-1:0];
    return sh[SAMPLE_W-1];
  endfunction

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    b_d        = b_q;
    sclk_d     = sclk_q;
    lrclk_d    = lrclk_q;
    data_d     = data_q;
    fs_d       = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    act_l_d    = act_l_q;
    act_r_d    = act_r_q;
    prev_r_d   = prev_r_q;
    shift_out  = 1'b0;
    uf_set     = 1'b0;
    accept     = s_if.s_valid && !pend_vld_q;

    // Acceptance and consumption never coincide: one needs the buffer
    // empty, the other full.
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_l_d   = s_if.s_left;
      pend_r_d   = s_if.s_right;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        data_d    = 1'b0;
        div_cnt_d = '0;
        b_d       = '0;
        if (enable && pend_vld_q) begin
          act_l_d    = pend_l_q;
          act_r_d    = pend_r_q;
          pend_vld_d = 1'b0;
          fs_d       = 1'b1;
          shift_out  = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          sclk_d    = !sclk_q;
          if (sclk_q) begin
            b_d = b_q + BW'(1);
            if (&b_q) begin
              prev_r_d = act_r_q;
              if (!enable) begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                lrclk_d = 1'b0;
                data_d  = 1'b0;
              end else begin
                fs_d      = 1'b1;
                shift_out = 1'b1;
                if (pend_vld_q) begin
                  act_l_d    = pend_l_q;
                  act_r_d    = pend_r_q;
                  pend_vld_d = 1'b0;
                end else begin
                  act_l_d = '0;
                  act_r_d = '0;
                  uf_set  = 1'b1;
                end
              end
            end else begin
              shift_out = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        data_d    = 1'b0;
        div_cnt_d = '0;
        b_d       = '0;
      end
    endcase

    if (shift_out) begin
      lrclk_d = b_d[BW-1];
      data_d  = slot_bit(b_d, act_l_d, act_r_d, prev_r_d);
    end

    // A new underflow wins over a simultaneous clear.
    if (uf_set)             uf_d = 1'b1;
    else if (underflow_clr) uf_d = 1'b0;
    else                    uf_d = uf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      b_q        <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      data_q     <= 1'b0;
      fs_q       <= 1'b0;
      uf_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      act_l_q    <= '0;
      act_r_q    <= '0;
      prev_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      b_q        <= b_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      data_q     <= data_d;
      fs_q       <= fs_d;
      uf_q       <= uf_d;
      pend_vld_q <= pend_vld_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
      prev_r_q   <= prev_r_d;
    end
  end

  assign s_if.s_ready = !pend_vld_q;
  assign i2s_sclk     = sclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_data     = data_q;
  assign frame_start  = fs_q;
  assign underflow    = uf_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_sequencer
// Directed scenarios followed by a randomized run. A frame-level reference
// model (cycle count since frame start, one-entry buffer, sticky flag)
// predicts every output each cycle; extra directed checks cover frame bit
// patterns, frame spacing, underflow clear priority, stop/restart and reset.
// ---------------------------------------------------------------------------
module tb_i2s_tx_sequencer;
  localparam int CLK_DIV  = 2;
  localparam int SAMPLE_W = 24;
  localparam int SLOT_W   = 32;
  localparam int NB       = 2 * SLOT_W;
  localparam int FRAME    = NB * 2 * CLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic underflow_clr = 1'b0;
  logic i2s_sclk, i2s_lrclk, i2s_data, frame_start, underflow, busy;

  always #5 clk = ~clk;

  i2s_tx_sequencer_if #(.SAMPLE_W(SAMPLE_W)) sif ();

  i2s_tx_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .s_if          (sif),
    .underflow_clr (underflow_clr),
    .i2s_sclk      (i2s_sclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_data      (i2s_data),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit                  m_run, m_pend, m_uf, m_fs;
  int                  m_t;
  logic [SAMPLE_W-1:0] m_cl, m_cr, m_prev, m_pl, m_pr;

  task automatic model_step();
    bit acc, set_uf;
    if (reset) begin
      m_run = 0; m_pend = 0; m_uf = 0; m_fs = 0; m_t = 0;
      m_cl = '0; m_cr = '0; m_prev = '0; m_pl = '0; m_pr = '0;
    end else begin
      acc    = sif.s_valid && !m_pend;
      set_uf = 0;
      m_fs   = 0;
      if (!m_run) begin
        if (enable && m_pend) begin
          m_cl = m_pl; m_cr = m_pr; m_pend = 0;
          m_run = 1; m_t = 0; m_fs = 1;
        end
      end else begin
        m_t++;
        if (m_t == FRAME) begin
          m_t = 0;
          m_prev = m_cr;
          if (!enable) m_run = 0;
          else begin
            m_fs = 1;
            if (m_pend) begin m_cl = m_pl; m_cr = m_pr; m_pend = 0; end
            else begin m_cl = '0; m_cr = '0; set_uf = 1; end
          end
        end
      end
      if (acc) begin m_pend = 1; m_pl = sif.s_left; m_pr = sif.s_right; end
      if (set_uf) m_uf = 1;
      else if (underflow_clr) m_uf = 0;
    end
  endtask

  function automatic logic m_data();
    int b, d, p;
    logic [SAMPLE_W-1:0] ch;
    b = (m_t / (2 * CLK_DIV)) % NB;
    d = (b + NB - 1) % NB;
    p = d % SLOT_W;
    if (b == 0)           ch = m_prev;
    else if (d >= SLOT_W) ch = m_cr;
    else                  ch = m_cl;
    if (p < SAMPLE_W) return ch[SAMPLE_W-1-p];
    return 1'b0;
  endfunction

  // {sclk, lrclk, data, frame_start, underflow, busy, s_ready}
  function automatic logic [6:0] m_expect();
    logic sc, lr, dt;
    sc = 0; lr = 0; dt = 0;
    if (m_run) begin
      sc = ((m_t / CLK_DIV) % 2) == 1;
      lr = ((m_t / (2 * CLK_DIV)) % NB) >= SLOT_W;
      dt = m_data();
    end
    return {sc, lr, dt, m_fs, m_uf, m_run, !m_pend};
  endfunction

  // ---------------- cycle driver / monitors ----------------
  int          cyc = 0;
  logic        prev_sclk = 1'b0;
  logic [63:0] cap = '0;
  int          cap_cnt = 0;
  logic [63:0] last_frame = '0;
  bit          t3_on = 0, have_last = 0;
  int          last_fs = 0, fs_cnt = 0;

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("outs", {i2s_sclk, i2s_lrclk, i2s_data, frame_start, underflow, busy, sif.s_ready},
        m_expect());
    if (frame_start === 1'b1) begin
      if (cap_cnt == 64) last_frame = cap;
      cap = {63'd0, i2s_data};
      cap_cnt = 1;
      if (t3_on) begin
        if (have_last) chk("fs_period", cyc - last_fs, FRAME);
        last_fs = cyc; have_last = 1; fs_cnt++;
      end
      $display("frame_start cyc=%0d uf=%0b", cyc, underflow);
    end else if (prev_sclk && !i2s_sclk) begin
      cap = {cap[62:0], i2s_data};
      cap_cnt++;
    end
    prev_sclk = i2s_sclk;
  endtask

  task automatic wait_t(input int tt);
    int n;
    n = 0;
    while (!(m_run && m_t == tt) && n < 3 * FRAME) begin
      cycle();
      n++;
    end
    if (!(m_run && m_t == tt)) chk("wait_timeout", 0, 1);
  endtask

  logic [63:0] exp1;
  int          mode;

  initial begin
    sif.s_valid = 1'b0;
    sif.s_left  = '0;
    sif.s_right = '0;

    // 1: reset held three cycles
    reset = 1'b1;
    repeat (3) cycle();
    chk("rst_ready", sif.s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {i2s_sclk, i2s_lrclk, i2s_data, frame_start, underflow}, 0);
    reset = 1'b0;
    cycle();

    // 2: one pair, check serial frame
    enable = 1'b1;
    sif.s_valid = 1'b1; sif.s_left = 24'hABCDEF; sif.s_right = 24'h123456;
    cycle();
    sif.s_valid = 1'b0;
    cycle();
    chk("first_fs", frame_start, 1);
    chk("first_busy", busy, 1);
    repeat (FRAME) cycle();
    exp1 = {1'b0, 24'hABCDEF, 8'h00, 24'h123456, 7'h00};
    chk("frame1_bits", last_frame, exp1);

    // 4: silent frame and underflow flag
    chk("uf_set", underflow, 1);
    underflow_clr = 1'b1;
    cycle();
    underflow_clr = 1'b0;
    chk("uf_clr", underflow, 0);
    wait_t(FRAME - 1);
    underflow_clr = 1'b1;
    cycle();
    underflow_clr = 1'b0;
    chk("uf_set_beats_clr", underflow, 1);
    chk("silent_bits", last_frame, 64'd0);
    underflow_clr = 1'b1;
    cycle();
    underflow_clr = 1'b0;

    // 3: continuous supply, new random pair offered every cycle
    t3_on = 1; have_last = 0; fs_cnt = 0;
    sif.s_valid = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      sif.s_left  = SAMPLE_W'($urandom());
      sif.s_right = SAMPLE_W'($urandom());
      cycle();
    end
    t3_on = 0;
    chk("stream_uf", underflow, 0);
    chk("stream_fs_cnt", fs_cnt, 8);

    // 5: drop enable mid-frame, frame completes, pending retained
    wait_t(10 * 2 * CLK_DIV);
    enable = 1'b0;
    for (int n = 0; n < 2 * FRAME && m_run; n++) cycle();
    chk("stop_busy", busy, 0);
    chk("stop_pend_kept", sif.s_ready, 0);
    sif.s_valid = 1'b0;
    repeat (3) cycle();
    enable = 1'b1;
    cycle();
    chk("restart_fs", frame_start, 1);
    chk("restart_busy", busy, 1);

    // 6: reset mid-frame with a pair pending
    sif.s_valid = 1'b1;
    sif.s_left = SAMPLE_W'($urandom()); sif.s_right = SAMPLE_W'($urandom());
    cycle();
    sif.s_valid = 1'b0;
    wait_t(40 * 2 * CLK_DIV);
    chk("pend_before_rst", sif.s_ready, 0);
    reset = 1'b1;
    cycle();
    chk("rst_mid_ready", sif.s_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pins", {i2s_sclk, i2s_lrclk, i2s_data, frame_start}, 0);
    reset = 1'b0;
    repeat (20) cycle();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_uf", underflow, 0);

    // randomized run against the model
    mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       sif.s_valid = 1'b0;
        1:       sif.s_valid = ($urandom_range(0, 199) == 0);
        default: sif.s_valid = ($urandom_range(0, 1) == 0);
      endcase
      sif.s_left    = SAMPLE_W'($urandom());
      sif.s_right   = SAMPLE_W'($urandom());
      underflow_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) enable = !enable;
      reset = ($urandom_range(0, 1999) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
